uart_frame_tx: RTL and testbench

UART_FRAME_TX -- requirements
Module: uart_frame_tx

---
 rtl/uart_frame_pkg.sv | 22 ++
 rtl/uart_frame_tx_if.sv | 9 +
 rtl/uart_tx_fifo.sv | 51 +++++
 rtl/uart_frame_tx.sv | 125 ++++++++++++
 tb/tb_uart_frame_tx.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared parity/FSM enums, bit-count constants and parity helper for the UART transmitter
package uart_frame_pkg;
    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_e;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;
    // wide enough to index up to 9 data bits
    localparam int BIT_CNT_W     = 4;
    localparam int MAX_STOP_BITS = 2;
    function automatic logic parity_bit(input logic data_xor, input parity_e mode);
        return data_xor ^ (mode == PAR_ODD);
    endfunction
endpackage

// File: rtl/uart_frame_tx_if.sv
// uart_frame_tx_if: valid/ready write channel into the UART transmit FIFO
// Signals: wr_valid (request), wr_data (payload, LSB sent first), wr_ready (FIFO can accept)
interface uart_frame_tx_if #(parameter int DATA_W = 8);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with registered pointers and occupancy level
// Ports: clk, rst (async active-high), push_valid/push_data/push_ready, pop/pop_data, level, empty
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    input  logic [DATA_W-1:0]        push_data,
    output logic                     push_ready,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          live_q;
    logic          do_push, do_pop;
    // ready stays low during reset and rises on the first edge after release
    assign push_ready = live_q && (level_q < (AW+1)'(DEPTH));
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop && !empty;
    assign empty      = (level_q == '0);
    assign level      = level_q;
    assign pop_data   = mem_q[rd_ptr_q];
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            live_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            live_q   <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: FIFO-buffered UART frame transmitter (start, data LSB first, optional parity, 1/2 stop bits)
// Ports: HCLK, RESET (async active-high), wr (uart_frame_tx_if.slave), baud_div, parity_mode, stop2,
//        CTS (only with UART_FRAME_TX_CTS_EN), TXD, busy, fifo_level, tx_done
// Define UART_FRAME_TX_CTS_EN to add the active-low CTS input gating frame starts.
module uart_frame_tx import uart_frame_pkg::*; #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          HCLK,
    input  logic                          RESET,
    uart_frame_tx_if.slave                wr,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop2,
`ifdef UART_FRAME_TX_CTS_EN
    input  logic                          CTS,
`endif
    output logic                          TXD,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx_done
);
    state_e                 state_q, state_d;
    logic [DIV_W-1:0]       cnt_q, cnt_d, div_q, div_d, div_load;
    logic [BIT_CNT_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0]      shift_q, shift_d, head;
    logic                   par_q, par_d, par_en_q, par_en_d, stop2_q, stop2_d;
    logic                   pop, empty, can_start, load, bit_end, last_data;
    parity_e                pm;
    uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (HCLK),
        .rst        (RESET),
        .push_valid (wr.wr_valid),
        .push_data  (wr.wr_data),
        .push_ready (wr.wr_ready),
        .pop        (pop),
        .pop_data   (head),
        .level      (fifo_level),
        .empty      (empty)
    );
`ifdef UART_FRAME_TX_CTS_EN
    assign can_start = !empty && !CTS;
`else
    assign can_start = !empty;
`endif
    assign pm        = parity_e'(parity_mode);
    // counter holds cycles-per-bit minus one, so a divider of 0 or 1 both give one cycle
    assign div_load  = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
    assign bit_end   = (cnt_q == '0);
    assign last_data = (bit_q == BIT_CNT_W'(DATA_W - 1));
    assign busy      = (state_q != ST_IDLE);
    assign TXD       = (state_q == ST_START)  ? 1'b0 :
                       (state_q == ST_DATA)   ? shift_q[0] :
                       (state_q == ST_PARITY) ? par_q : 1'b1;
    always_comb begin
        state_d  = state_q;
        cnt_d    = (state_q == ST_IDLE) ? cnt_q : bit_end ? div_q : cnt_q - DIV_W'(1);
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        par_en_d = par_en_q;
        stop2_d  = stop2_q;
        tx_done  = 1'b0;
        load     = 1'b0;
        case (state_q)
            ST_IDLE:   load = can_start;
            ST_START:  state_d = bit_end ? ST_DATA : ST_START;
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = last_data ? '0 : bit_q + BIT_CNT_W'(1);
                    state_d = !last_data ? ST_DATA : par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: state_d = bit_end ? ST_STOP : ST_PARITY;
            ST_STOP: begin
                if (bit_end) begin
                    if (stop2_q && bit_q != BIT_CNT_W'(MAX_STOP_BITS - 1)) begin
                        bit_d = bit_q + BIT_CNT_W'(1);
                    end else begin
                        tx_done = 1'b1;
                        state_d = ST_IDLE;
                        load    = can_start;
                    end
                end
            end
            default:   state_d = ST_IDLE;
        endcase
        // a load from IDLE or from the final stop bit starts the next frame with no idle bit
        if (load) begin
            state_d  = ST_START;
            cnt_d    = div_load;
            div_d    = div_load;
            bit_d    = '0;
            shift_d  = head;
            par_en_d = (pm == PAR_EVEN) || (pm == PAR_ODD);
            par_d    = parity_bit(^head, pm);
            stop2_d  = stop2;
        end
    end
    assign pop = load;
    always_ff @(posedge HCLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            par_en_q <= par_en_d;
            stop2_q  <= stop2_d;
        end
    end
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: scoreboard bench for uart_frame_tx (8-bit and 7-bit instances)
module tb_uart_frame_tx;
    typedef struct {
        logic [7:0] d;
        logic [1:0] pm;
        logic       s2;
        int         div;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    logic hclk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] baud_div = 16'd64;
    logic [1:0]  parity_mode = 2'b00;
    logic        stop2 = 1'b0;
    logic txd, busy, tx_done;
    logic [4:0] fifo_level;
    logic txd7, busy7, done7;
    logic [4:0] level7;
`ifdef UART_FRAME_TX_CTS_EN
    logic cts = 1'b0;
`endif
    always #5 hclk = ~hclk;
    uart_frame_tx_if #(.DATA_W(8)) wr_if ();
    uart_frame_tx_if #(.DATA_W(7)) wr7_if ();
    uart_frame_tx #(.DATA_W(8), .FIFO_DEPTH(16), .DIV_W(16)) dut (
        .HCLK(hclk), .RESET(reset), .wr(wr_if), .baud_div(baud_div), .parity_mode(parity_mode),
        .stop2(stop2),
`ifdef UART_FRAME_TX_CTS_EN
        .CTS(cts),
`endif
        .TXD(txd), .busy(busy), .fifo_level(fifo_level), .tx_done(tx_done));
    uart_frame_tx #(.DATA_W(7), .FIFO_DEPTH(16), .DIV_W(16)) dut7 (
        .HCLK(hclk), .RESET(reset), .wr(wr7_if), .baud_div(16'd1), .parity_mode(2'b00),
        .stop2(1'b0),
`ifdef UART_FRAME_TX_CTS_EN
        .CTS(1'b0),
`endif
        .TXD(txd7), .busy(busy7), .fifo_level(level7), .tx_done(done7));

    // called at a negedge; returns at the following negedge after the write edge
    task automatic push(input logic [7:0] d, output bit acc);
        exp_t e;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = d;
        acc = wr_if.wr_ready;
        if (acc) begin
            e.d = d; e.pm = parity_mode; e.s2 = stop2; e.div = int'(baud_div);
            sb.push_back(e);
        end
        @(negedge hclk);
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic check_frame(input bit imm, input int max_wait, output int lat);
        exp_t e;
        logic b [12];
        int nb, div, total, bad_bit, bad_done, bad_busy;
        lat = -1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: got no expected frame, want one queued");
            return;
        end
        e = sb.pop_front();
        div = (e.div < 1) ? 1 : e.div;
        nb = 0;
        b[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin b[nb] = e.d[i]; nb++; end
        if (e.pm == 2'b01 || e.pm == 2'b10) begin b[nb] = (^e.d) ^ (e.pm == 2'b10); nb++; end
        b[nb] = 1'b1; nb++;
        if (e.s2) begin b[nb] = 1'b1; nb++; end
        lat = 0;
        @(negedge hclk);
        while (txd !== 1'b0 && lat < max_wait) begin lat++; @(negedge hclk); end
        if (txd !== 1'b0) begin
            errors++;
            $display("FAIL start_timeout: data %h got txd %b after %0d cycles, want start bit", e.d, txd, lat);
            return;
        end
        if (imm) begin
            checks++;
            if (lat != 0) begin errors++; $display("FAIL start_latency: data %h got %0d, want 0", e.d, lat); end
        end
        total = nb * div;
        bad_bit = 0; bad_done = 0; bad_busy = 0;
        for (int c = 1; c <= total; c++) begin
            if (c > 1) @(negedge hclk);
            if (bad_bit == 0 && txd !== b[(c-1)/div]) bad_bit = c;
            if (bad_done == 0 && tx_done !== (c == total)) bad_done = c;
            if (bad_busy == 0 && busy !== 1'b1) bad_busy = c;
        end
        checks += 3;
        if (bad_bit != 0) begin errors++; $display("FAIL frame_bits: data %h cycle %0d got %b want %b", e.d, bad_bit, txd, b[(bad_bit-1)/div]); end
        if (bad_done != 0) begin errors++; $display("FAIL tx_done: data %h wrong at cycle %0d, want pulse only at cycle %0d", e.d, bad_done, total); end
        if (bad_busy != 0) begin errors++; $display("FAIL frame_busy: data %h got 0 at cycle %0d, want 1", e.d, bad_busy); end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge hclk);
        checks += 5;
        if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", tx_done); end
        if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", wr_if.wr_ready); end
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        reset = 1'b0;
        #1;
        checks++;
        if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL ready_pre_edge: got %b want 0", wr_if.wr_ready); end
        @(negedge hclk);
        checks++;
        if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL ready_post_edge: got %b want 1", wr_if.wr_ready); end
    endtask

    task automatic test_basic;
        bit acc; int lat;
        baud_div = 16'd64; parity_mode = 2'b00; stop2 = 1'b0;
        push(8'h55, acc);
        checks++;
        if (!acc) begin errors++; $display("FAIL basic_accept: got 0 want 1"); end
        check_frame(1, 200, lat);
        @(negedge hclk);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
        if (txd !== 1'b1) begin errors++; $display("FAIL basic_idle_txd: got %b want 1", txd); end
    endtask

    task automatic test_parity;
        bit acc; int lat;
        logic [1:0] pms [5] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b11};
        logic       s2s [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] dvs [5] = '{16'd64, 16'd64, 16'd64, 16'd0, 16'd2};
        logic [7:0] dat [5] = '{8'h41, 8'h41, 8'h41, 8'hA5, 8'h3C};
        for (int i = 0; i < 5; i++) begin
            parity_mode = pms[i]; stop2 = s2s[i]; baud_div = dvs[i];
            push(dat[i], acc);
            check_frame(1, 200, lat);
            @(negedge hclk);
        end
        parity_mode = 2'b00; stop2 = 1'b0;
    endtask

    task automatic test_back_to_back;
        bit acc; int lat; int n_acc;
        baud_div = 16'd8;
        push(8'h11, acc);
        fork
            begin
                check_frame(1, 200, lat);
                for (int i = 0; i < 16; i++) check_frame(1, 4, lat);
            end
            begin
                exp_t e;
                n_acc = 0;
                for (int i = 0; i < 17; i++) begin
                    wr_if.wr_valid = 1'b1;
                    wr_if.wr_data  = 8'hA0 + 8'(i);
                    if (wr_if.wr_ready) begin
                        e.d = wr_if.wr_data; e.pm = parity_mode; e.s2 = stop2; e.div = int'(baud_div);
                        sb.push_back(e);
                        n_acc++;
                    end
                    @(negedge hclk);
                end
                wr_if.wr_valid = 1'b0;
                checks += 3;
                if (n_acc != 16) begin errors++; $display("FAIL full_accepts: got %0d want 16", n_acc); end
                if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_level: got %0d want 16", fifo_level); end
                if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", wr_if.wr_ready); end
            end
        join
        @(negedge hclk);
        checks++;
        if (busy !== 1'b0 || fifo_level !== 5'd0) begin errors++; $display("FAIL b2b_drain: got busy %b level %0d want 0 0", busy, fifo_level); end
    endtask

    task automatic test_reset_mid;
        bit acc; int lat;
        baud_div = 16'd8;
        push(8'h3C, acc);
        push(8'h99, acc);
        repeat (34) @(negedge hclk);
        checks += 2;
        if (txd !== 1'b1) begin errors++; $display("FAIL mid_bit3: got %b want 1", txd); end
        if (fifo_level !== 5'd1) begin errors++; $display("FAIL mid_level: got %0d want 1", fifo_level); end
        reset = 1'b1;
        #1;
        checks += 4;
        if (txd !== 1'b1) begin errors++; $display("FAIL abort_txd: got %b want 1", txd); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL abort_level: got %0d want 0", fifo_level); end
        if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", wr_if.wr_ready); end
        sb.delete();
        @(negedge hclk);
        reset = 1'b0;
        @(negedge hclk);
        push(8'hA5, acc);
        checks++;
        if (!acc) begin errors++; $display("FAIL post_reset_accept: got 0 want 1"); end
        check_frame(1, 200, lat);
        @(negedge hclk);
    endtask

`ifdef UART_FRAME_TX_CTS_EN
    task automatic test_cts;
        bit acc; int lat; int bad;
        baud_div = 16'd4;
        cts = 1'b1;
        push(8'h28, acc);
        bad = 0;
        repeat (20) begin
            @(negedge hclk);
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks += 2;
        if (bad != 0) begin errors++; $display("FAIL cts_hold: got %0d active cycles want 0", bad); end
        if (fifo_level !== 5'd1) begin errors++; $display("FAIL cts_level: got %0d want 1", fifo_level); end
        cts = 1'b0;
        fork
            check_frame(0, 10, lat);
            begin repeat (15) @(negedge hclk); cts = 1'b1; end
        join
        checks++;
        if (lat < 0 || lat > 2) begin errors++; $display("FAIL cts_latency: got %0d want <=2", lat); end
        cts = 1'b0;
        @(negedge hclk);
    endtask
`endif

    task automatic test_dw7;
        int bad_bit, bad_done, bad_busy;
        wr7_if.wr_valid = 1'b1;
        wr7_if.wr_data  = 7'h7F;
        checks++;
        if (wr7_if.wr_ready !== 1'b1) begin errors++; $display("FAIL dw7_ready: got %b want 1", wr7_if.wr_ready); end
        @(negedge hclk);
        wr7_if.wr_valid = 1'b0;
        bad_bit = 0; bad_done = 0; bad_busy = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge hclk);
            if (bad_bit == 0 && txd7 !== (c != 1)) bad_bit = c;
            if (bad_done == 0 && done7 !== (c == 9)) bad_done = c;
            if (bad_busy == 0 && busy7 !== 1'b1) bad_busy = c;
        end
        @(negedge hclk);
        checks += 4;
        if (bad_bit != 0) begin errors++; $display("FAIL dw7_bits: wrong txd %b at cycle %0d", txd7, bad_bit); end
        if (bad_done != 0) begin errors++; $display("FAIL dw7_done: wrong at cycle %0d, want pulse only at 9", bad_done); end
        if (bad_busy != 0) begin errors++; $display("FAIL dw7_busy: got 0 at cycle %0d want 1", bad_busy); end
        if (busy7 !== 1'b0 || level7 !== 5'd0) begin errors++; $display("FAIL dw7_end: got busy %b level %0d want 0 0", busy7, level7); end
    endtask

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;
        wr7_if.wr_valid = 1'b0;
        wr7_if.wr_data  = '0;
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_FRAME_TX_CTS_EN
        test_cts();
`endif
        test_dw7();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
